// File: rtl/apb_master_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : apb_master_bridge_pkg
// Brief   : Shared state encodings and APB constants for the APB master bridge.
// Revision: 1.0 - initial release
// ============================================================================
package apb_master_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : apb_wait_timer
// Brief   : Saturating wait-state counter; flags the last permitted wait cycle.
// Revision: 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = ^{clk, rst_n, clear, enable};
            assign expired  = 1'b0;
        end else begin : g_enabled
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(TIMEOUT);
            localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] r_count;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (enable && (r_count != C_MAX)) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // Fires during the TIMEOUT-th waiting cycle, before the count lands on TIMEOUT.
            assign expired = enable && (r_count >= C_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module  : apb_master_bridge
// Brief   : Single-transfer valid/ready to APB3/APB4 master with wait timeout.
// Revision: 1.0 - initial release
// ============================================================================
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int STRB_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [2:0]            pprot,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0] pstrb,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pslverr
);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_strb;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  r_timeout;
    logic                  w_accept;
    logic                  w_timer_enable;
    logic                  w_expired;

    assign w_accept       = (r_state == ST_IDLE) && req_valid;
    assign w_timer_enable = (r_state == ST_ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (pclk),
        .rst_n   (presetn),
        .clear   (w_accept),
        .enable  (w_timer_enable),
        .expired (w_expired)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_next_state = ST_SETUP;
            ST_SETUP:  w_next_state = ST_ACCESS;
            ST_ACCESS: if (pready || w_expired) w_next_state = ST_RESP;
            ST_RESP:   if (rsp_ready) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                // Reads never expose stale write data or strobes on the bus.
                r_wdata <= req_write ? req_wdata : '0;
                r_strb  <= req_write ? req_strb  : '0;
            end
            if (r_state == ST_ACCESS) begin
                if (pready) begin
                    r_rdata   <= r_write ? '0 : prdata;
                    r_err     <= pslverr;
                    r_timeout <= 1'b0;
                end else if (w_expired) begin
                    r_rdata   <= '0;
                    r_err     <= 1'b1;
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign psel        = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign penable     = (r_state == ST_ACCESS);
    assign paddr       = r_addr;
    assign pwrite      = r_write;
    assign pwdata      = r_wdata;
    assign pstrb       = r_strb;
    assign pprot       = PPROT_DEFAULT;
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;
    assign rsp_timeout = r_timeout;

endmodule
`default_nettype wire
